// File: rtl/mux_rr_reg.sv
// N-channel valid/ready selector with round-robin or fixed-priority arbitration.
// The winning word is captured in a single output register, tagged with its source channel.
module mux_rr_reg #(
  parameter int N          = 32,
  parameter int CHANNELS   = 4,
  parameter int FIXED_PRIO = 0,
  parameter int SELW       = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   in_valid,
  input  logic [CHANNELS*N-1:0] in_data,
  output logic [CHANNELS-1:0]   in_ready,
  output logic                  out_valid,
  output logic [N-1:0]          out_data,
  output logic [SELW-1:0]       out_sel,
  input  logic                  out_ready
);

  logic                  out_valid_q, out_valid_d;
  logic [N-1:0]          out_data_q, out_data_d;
  logic [SELW-1:0]       out_sel_q, out_sel_d;
  logic [SELW-1:0]       ptr_q, ptr_d;

  logic                  can_load_s;
  logic                  any_valid_s;
  logic                  xfer_s;
  logic [SELW-1:0]       start_s;
  logic [2*CHANNELS-1:0] req2_s;
  logic [CHANNELS-1:0]   rot_s;
  logic [CHANNELS-1:0]   rot_oh_s;
  logic [CHANNELS-1:0]   gnt_oh_s;
  logic [SELW-1:0]       grant_s;
  logic [N-1:0]          data_s;
  logic [SELW-1:0][CHANNELS-1:0] enc_cols_s;
  logic [N-1:0][CHANNELS-1:0]    data_cols_s;

  assign start_s     = (FIXED_PRIO != 0) ? {SELW{1'b0}} : ptr_q;
  assign can_load_s  = ~out_valid_q | out_ready;
  assign any_valid_s = |in_valid;
  assign xfer_s      = any_valid_s & can_load_s;

  // Rotate requests so the search origin sits at bit 0, isolate the lowest set bit,
  // then rotate the one-hot grant back into channel order. Works for any CHANNELS.
  assign req2_s   = {in_valid, in_valid};
  assign rot_s    = CHANNELS'(req2_s >> start_s);
  assign rot_oh_s = rot_s & (~rot_s + CHANNELS'(1'b1));
  assign gnt_oh_s = CHANNELS'(({rot_oh_s, rot_oh_s} << start_s) >> CHANNELS);

  assign in_ready = gnt_oh_s & {CHANNELS{can_load_s & rst_n}};

  // AND-OR select: a zero grant bit forces its term to 0, so X on idle channels is masked.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    for (genvar b = 0; b < SELW; b++) begin : g_enc
      localparam bit IBIT = ((i >> b) % 2) == 1;
      assign enc_cols_s[b][i] = gnt_oh_s[i] & IBIT;
    end
    for (genvar k = 0; k < N; k++) begin : g_dat
      assign data_cols_s[k][i] = gnt_oh_s[i] & in_data[i*N + k];
    end
  end

  for (genvar b = 0; b < SELW; b++) begin : g_enc_or
    assign grant_s[b] = |enc_cols_s[b];
  end

  for (genvar k = 0; k < N; k++) begin : g_dat_or
    assign data_s[k] = |data_cols_s[k];
  end

  // Output register and pointer next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = data_s;
      out_sel_d   = grant_s;
      if (FIXED_PRIO == 0) begin
        ptr_d = (grant_s == SELW'(CHANNELS - 1)) ? {SELW{1'b0}} : grant_s + SELW'(1'b1);
      end else begin
        ptr_d = ptr_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; any held word is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {N{1'b0}};
      out_sel_q   <= {SELW{1'b0}};
      ptr_q       <= {SELW{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
